// File: rtl/mips_cpu_load_store_unit_pkg.sv
// Shared opcodes, state type and lane helpers
// for the MIPS load/store unit.
package mips_cpu_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  function automatic logic op_legal(
    input logic [5:0] op,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LB, OP_LBU, OP_SB,
      OP_LWL, OP_LWR:        ok = 1'b1;
      OP_LH, OP_LHU, OP_SH:  ok = ~a[0];
      OP_LW, OP_SW:          ok = (a == 2'b00);
      default:               ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [5:0] op,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b1111;
    case (op)
      OP_SB:   be = 4'b0001 << a;
      OP_SH:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wd(
    input logic [5:0]  op,
    input logic [31:0] d
  );
    logic [31:0] w;
    case (op)
      OP_SB:   w = {4{d[7:0]}};
      OP_SH:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mips_cpu_load_store_unit_if.sv
// Avalon-MM master bus between the load/store
// unit and memory.
interface mips_cpu_load_store_unit_if;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_byteenable,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_byteenable,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/mips_cpu_load_extend.sv
// Load lane selection, sign/zero extension and
// LWL/LWR merge with the old rt value.
module mips_cpu_load_extend
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  ofs,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] load_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{ofs, 3'b000} +: 8];
    h = ofs[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (opcode)
      OP_LB:  load_data = {{24{b[7]}}, b};
      OP_LBU: load_data = {24'h0, b};
      OP_LH:  load_data = {{16{h[15]}}, h};
      OP_LHU: load_data = {16'h0, h};
      OP_LWL: begin
        case (ofs)
          2'd0:    load_data = {rdata[7:0], rt_old[23:0]};
          2'd1:    load_data = {rdata[15:0], rt_old[15:0]};
          2'd2:    load_data = {rdata[23:0], rt_old[7:0]};
          default: load_data = rdata;
        endcase
      end
      OP_LWR: begin
        case (ofs)
          2'd0:    load_data = rdata;
          2'd1:    load_data = {rt_old[31:24], rdata[31:8]};
          2'd2:    load_data = {rt_old[31:16], rdata[31:16]};
          default: load_data = {rt_old[31:8], rdata[31:24]};
        endcase
      end
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// Multi-cycle Avalon-MM load/store engine fed by
// the ALU effective address.
module mips_cpu_load_store_unit
  import mips_cpu_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] eff_addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_old,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_error,
  mips_cpu_load_store_unit_if.master avm
);

  localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

  lsu_state_t  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  ofs_q, ofs_d;
  logic [31:0] rt_q, rt_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] ld_q, ld_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] ext_data;

  mips_cpu_load_extend u_ext (
    .opcode    (op_q),
    .ofs       (ofs_q),
    .rdata     (avm.avm_readdata),
    .rt_old    (rt_q),
    .load_data (ext_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ofs_d   = ofs_q;
    rt_d    = rt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ld_d    = ld_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (start && op_legal(opcode, eff_addr[1:0])) begin
          op_d    = opcode;
          ofs_d   = eff_addr[1:0];
          rt_d    = rt_old;
          addr_d  = {eff_addr[31:2], 2'b00};
          be_d    = lane_be(opcode, eff_addr[1:0]);
          wd_d    = lane_wd(opcode, store_data);
          rd_d    = ~opcode[3];
          wr_d    = opcode[3];
          state_d = REQ;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      REQ: begin
        if (!avm.avm_waitrequest) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (wr_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          ld_d    = ext_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      ofs_q   <= '0;
      rt_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ofs_q   <= ofs_d;
      rt_q    <= rt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
    end
  end

  assign busy               = (state_q != IDLE);
  assign done               = done_q;
  assign addr_error         = err_q;
  assign load_data          = ld_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = rd_q;
  assign avm.avm_write      = wr_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_writedata  = wd_q;

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
// Randomized bench for the load/store unit against
// a byte-arithmetic reference model.
module tb_mips_cpu_load_store_unit;

  localparam int RL = 1;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [5:0]  opcode;
  logic [31:0] eff_addr;
  logic [31:0] store_data;
  logic [31:0] rt_old;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        addr_error;
  logic [31:0] got_ld;

  int nvec = 0;
  int nerr = 0;

  mips_cpu_load_store_unit_if bus ();

  mips_cpu_load_store_unit #(
    .READ_LATENCY (RL)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .opcode     (opcode),
    .eff_addr   (eff_addr),
    .store_data (store_data),
    .rt_old     (rt_old),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .addr_error (addr_error),
    .avm        (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                           6'h25, 6'h26, 6'h28, 6'h29, 6'h2B};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic bit m_legal(input logic [5:0] op,
                                 input logic [31:0] addr);
    int sz;
    bit known;
    known = 0;
    foreach (ops[i]) if (ops[i] == op) known = 1;
    sz = 1;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) sz = 2;
    if (op == 6'h23 || op == 6'h2B) sz = 4;
    return known && (addr % sz == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op,
                                      input int a);
    if (op == 6'h28) return 4'(1 << a);
    if (op == 6'h29) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [5:0] op,
                                       input logic [31:0] sd);
    if (op == 6'h28) return 32'(sd[7:0]) * 32'h01010101;
    if (op == 6'h29) return 32'(sd[15:0]) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op,
                                         input int a,
                                         input logic [31:0] rd,
                                         input logic [31:0] rt);
    logic [31:0] v;
    logic [31:0] m;
    v = rd;
    case (op)
      6'h20, 6'h24: begin
        v = (rd >> (8 * a)) & 32'hFF;
        if (op == 6'h20 && v >= 128) v = v | 32'hFFFFFF00;
      end
      6'h21, 6'h25: begin
        v = (rd >> (16 * (a / 2))) & 32'hFFFF;
        if (op == 6'h21 && v >= 32768) v = v | 32'hFFFF0000;
      end
      6'h22: begin
        m = 32'hFFFFFFFF << (8 * (3 - a));
        v = (rd << (8 * (3 - a))) | (rt & ~m);
      end
      6'h26: begin
        m = 32'hFFFFFFFF >> (8 * a);
        v = (rd >> (8 * a)) | (rt & ~m);
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [5:0] op,
                        input logic [31:0] addr,
                        input logic [31:0] sd,
                        input logic [31:0] rt,
                        input logic [31:0] rdw,
                        input int nwait,
                        input bit poke);
    int a;
    bit ld;
    a  = int'(addr[1:0]);
    ld = (op[3] == 1'b0);
    @(negedge clk);
    start      = 1'b1;
    opcode     = op;
    eff_addr   = addr;
    store_data = sd;
    rt_old     = rt;
    bus.avm_readdata = $urandom;
    @(negedge clk);
    start      = 1'b0;
    opcode     = 6'($urandom);
    eff_addr   = $urandom;
    store_data = $urandom;
    rt_old     = $urandom;
    if (!m_legal(op, addr)) begin
      chk("err_pulse", 32'(addr_error), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_bus", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
      @(negedge clk);
      chk("err_clear", 32'(addr_error), 32'd0);
      chk("err_idle", 32'(busy), 32'd0);
      chk("err_bus2", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
      return;
    end
    chk("no_err", 32'(addr_error), 32'd0);
    for (int i = 0; i <= nwait; i++) begin
      chk("req_busy", 32'(busy), 32'd1);
      chk("req_done", 32'(done), 32'd0);
      chk("req_rd", 32'(bus.avm_read), 32'(ld));
      chk("req_wr", 32'(bus.avm_write), 32'(!ld));
      chk("req_addr", bus.avm_address, {addr[31:2], 2'b00});
      chk("req_be", 32'(bus.avm_byteenable), 32'(m_be(op, a)));
      if (!ld) chk("req_wd", bus.avm_writedata, m_wd(op, sd));
      bus.avm_waitrequest = (i < nwait);
      bus.avm_readdata = $urandom;
      if (poke && i == 0) begin
        start    = 1'b1;
        opcode   = ops[$urandom_range(0, 9)];
        eff_addr = $urandom & 32'hFFFFFFFC;
      end
      @(negedge clk);
      start = 1'b0;
    end
    bus.avm_waitrequest = 1'b0;
    if (ld) begin
      for (int i = 1; i <= RL; i++) begin
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_done", 32'(done), 32'd0);
        chk("wait_bus", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
        bus.avm_readdata = (i == RL) ? rdw : $urandom;
        @(negedge clk);
      end
    end
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_bus", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
    if (ld) chk("load", load_data, m_load(op, a, rdw, rt));
    got_ld = load_data;
    bus.avm_readdata = $urandom;
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
    chk("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    opcode = '0;
    eff_addr = '0;
    store_data = '0;
    rt_old = '0;
    got_ld = '0;
    bus.avm_readdata = '0;
    bus.avm_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(addr_error), 32'd0);
    chk("rst_bus", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
    chk("rst_addr", bus.avm_address, 32'd0);
    chk("rst_be", 32'(bus.avm_byteenable), 32'd0);
    chk("rst_wd", bus.avm_writedata, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    reset_n = 1'b1;

    run_op(6'h2B, 32'h1004, 32'hDEADBEEF, 0, 0, 0, 0);
    run_op(6'h28, 32'h1007, 32'h000000A5, 0, 0, 3, 1);
    run_op(6'h20, 32'h2002, 0, 0, 32'h80FF7F01, 0, 0);
    chk("lb_dir", got_ld, 32'hFFFFFFFF);
    run_op(6'h24, 32'h2002, 0, 0, 32'h80FF7F01, 0, 0);
    chk("lbu_dir", got_ld, 32'h000000FF);
    run_op(6'h21, 32'h2002, 0, 0, 32'h80FF7F01, 0, 0);
    chk("lh_dir", got_ld, 32'hFFFF80FF);
    run_op(6'h22, 32'h2001, 0, 32'h11223344, 32'hAABBCCDD, 1, 0);
    chk("lwl_dir", got_ld, 32'hCCDD3344);
    run_op(6'h26, 32'h2001, 0, 32'h11223344, 32'hAABBCCDD, 0, 1);
    chk("lwr_dir", got_ld, 32'h11AABBCC);
    run_op(6'h23, 32'h3002, 0, 0, 0, 0, 0);
    run_op(6'h29, 32'h3001, 32'h1234, 0, 0, 0, 0);
    run_op(6'h2F, 32'h3000, 0, 0, 0, 0, 0);

    @(negedge clk);
    start = 1'b1;
    opcode = 6'h23;
    eff_addr = 32'h4000;
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid_rd", 32'(bus.avm_read), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_drop", 32'(bus.avm_read), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    bus.avm_waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_nodone", 32'(done), 32'd0);
      chk("rst_mid_nobus", {30'd0, bus.avm_read, bus.avm_write}, 32'd0);
    end

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      logic [31:0] ad;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 9)];
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        if (op == 6'h23 || op == 6'h2B) ad[1:0] = 2'b00;
        if (op == 6'h21 || op == 6'h25 || op == 6'h29) ad[0] = 1'b0;
      end
      run_op(op, ad, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
